alu_issue_scheduler: RTL and testbench
======================================

// Module: alu_issue_scheduler
// PURPOSE
//  Sits between controlpath decode and the vector ALU. Holds each decoded instruction until its source and
//  destination registers are hazard-free, then issues it and pulses pc_inc. Tracks in-flight results in a
//  fixed-latency writeback pipe and a 16-entry pending scoreboard. Supports a drain request for mode switches.
// PARAMETERS
//  ALU_LAT   3   cycles from issue to writeback (>=1)
//  NREG      16  register count; select width = $clog2(NREG) = 4
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-high reset
//  instr_valid    in   1   decoded instruction present on select inputs
//  instr_ready    out  1   scheduler can issue this cycle
//  src_sel        in   16  {d,c,b,a}_select, 4 bits each, a in [3:0]
//  src_use        in   4   per-operand read enable, bit0=a; c bit is 0 when const_c
//  alu_Y1_select  in   4   destination 1
//  alu_Y2_select  in   4   destination 2
//  alu_write      in   2   bit0 writes Y1, bit1 writes Y2
//  zero_reg       in   4   hardwired-zero register index
//  drain          in   1   stop issuing until pipe empty
//  issue          out  1   instruction sent to ALU this cycle
//  pc_inc         out  1   equals issue
//  stall          out  1   instr_valid & !instr_ready
//  drained        out  1   drain & pipe empty & no pending bits
//  wb_valid       out  1   writeback this cycle
//  wb_Y1_select   out  4   writeback destination 1
//  wb_Y2_select   out  4   writeback destination 2
//  wb_write       out  2   writeback enables
//  pending        out  16  scoreboard, bit i = register i awaiting writeback
// BEHAVIOUR
//  - Reset (async, immediate): pending=0, pipe stages invalid, all outputs 0, except instr_ready=1 when drain=0.
//  - hazard = any used source, or any written destination, whose pending bit is set after same-cycle clear.
//    Reads or writes of zero_reg never hazard and never set pending.
//  - instr_ready = !drain & !hazard (combinational). issue = pc_inc = instr_valid & instr_ready.
//  - Issue: pushes {alu_write, Y1, Y2} into stage 0 of the ALU_LAT-deep pipe.
//    Sets pending[Y1] if alu_write[0] and pending[Y2] if alu_write[1], excluding zero_reg.
//  - Writeback: the last stage drives wb_* registered, exactly ALU_LAT cycles after issue.
//    While wb_valid, pending bits for its written destinations clear that same cycle.
//  - Same-cycle clear and read: a register being written back counts as free (zero-bubble back-to-back).
//  - Same-cycle clear and set of one bit: set wins.
//  - Y1==Y2 with alu_write=2'b11: one pending bit; wb_write still reports 2'b11.
//  - alu_write=0: the instruction still occupies the pipe slot and sets no bits.
//  - Stall: inputs are held by upstream. The scheduler keeps no copy; instr_valid may drop with no effect.
//  - Drain: in-flight ops complete normally. drained asserts the first cycle the pipe and pending are both
//    empty, and stays high while drain=1.
//  - Throughput: 1 instr/cycle absent hazards. Pipe never full; no backpressure from the ALU.
//  - Reset mid-operation discards all in-flight writebacks (no wb_valid after reset).
// STRUCTURE
//  - Package rapids_sched_pkg: REG_W=4, NREG=16, typedef wb_entry_t {logic[1:0] wr; logic[3:0] y1,y2;}.
//  - Sub-module alu_wb_pipe: ALU_LAT-stage shift register of wb_entry_t plus a valid bit, output = wb_*.
//  - Top: hazard compare, scoreboard register, handshake and drain logic.
// TESTING
//  1. Reset mid-run: pending=16'h0006 with 2 ops in flight; assert rst -> pending=0, no wb_valid in the next
//     5 cycles, instr_ready=1.
//  2. Independent stream: 6 instrs, Y1=1..6, srcs 8..11, ALU_LAT=3 -> issue every cycle, pc_inc x6,
//     wb_Y1_select=1..6 on cycles 3..8.
//  3. RAW: Y1=5 issued at t0, next instr a=5 -> stall at t1,t2; issue at t3 (wb clear same cycle); pending[5]
//     0 then 1 again only if rewritten.
//  4. Zero reg: zero_reg=0, write Y1=0 then read a=0 -> no stall, pending stays 16'h0000.
//  5. Dual write with Y1=Y2=7 and alu_write=2'b11 -> pending=16'h0080; at wb, wb_write=2'b11 and pending=0.
//  6. Drain: 2 ops in flight, drain=1 -> instr_ready=0, drained rises 1 cycle after last wb_valid clears pending.

Source files
------------

// File: rtl/rapids_sched_pkg.sv
// Shared widths and the writeback record carried through the ALU latency pipe.
// Imported by the scheduler top and its writeback pipe.
package rapids_sched_pkg;

    localparam int REG_W = 4;
    localparam int NREG  = 16;

    typedef struct packed {
        logic [1:0]       wr;
        logic [REG_W-1:0] y1;
        logic [REG_W-1:0] y2;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_pipe.sv
// Fixed-latency shift register tracking issued ALU ops until writeback.
// The last stage is presented directly as the registered writeback.
module alu_wb_pipe
    import rapids_sched_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_valid,
    input  wb_entry_t push_entry,
    output logic      wb_valid,
    output wb_entry_t wb_entry,
    output logic      busy
);

    logic      [LAT-1:0] valid_q, valid_d;
    wb_entry_t [LAT-1:0] entry_q, entry_d;

    always_comb begin
        valid_d    = '0;
        entry_d    = '0;
        valid_d[0] = push_valid;
        entry_d[0] = push_entry;
        for (int k = 1; k < LAT; k++) begin
            valid_d[k] = valid_q[k-1];
            entry_d[k] = entry_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign wb_valid = valid_q[LAT-1];
    assign wb_entry = entry_q[LAT-1];
    assign busy     = |valid_q;

endmodule

// File: rtl/alu_issue_scheduler.sv
// In-order issue gate for the vector ALU: holds decode until sources and destinations
// are clear of pending writebacks, then issues one instruction per cycle.
module alu_issue_scheduler
    import rapids_sched_pkg::*;
#(
    parameter int ALU_LAT = 3,
    parameter int NREG    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [4*REG_W-1:0] src_sel,
    input  logic [3:0]         src_use,
    input  logic [REG_W-1:0]   alu_Y1_select,
    input  logic [REG_W-1:0]   alu_Y2_select,
    input  logic [1:0]         alu_write,
    input  logic [REG_W-1:0]   zero_reg,
    input  logic               drain,
    output logic               issue,
    output logic               pc_inc,
    output logic               stall,
    output logic               drained,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_Y1_select,
    output logic [REG_W-1:0]   wb_Y2_select,
    output logic [1:0]         wb_write,
    output logic [NREG-1:0]    pending
);

    logic [NREG-1:0]             pending_q, pending_d;
    logic [NREG-1:0]             clr_mask, set_mask, pend_eff;
    logic [1:0][REG_W-1:0]       dst_sel;
    logic [3:0]                  src_hit;
    logic [1:0]                  dst_hit;
    logic                        hazard, active, pipe_busy, pipe_wb_valid;
    wb_entry_t                   push_entry, pipe_wb_entry;

    // Combinational outputs are suppressed while reset is held so nothing issues into a pipe being cleared.
    assign active  = !rst;
    assign dst_sel = {alu_Y2_select, alu_Y1_select};

    // Registers retiring this cycle count as free, giving zero-bubble RAW/WAW turnaround.
    always_comb begin
        clr_mask = '0;
        if (pipe_wb_valid) begin
            if (pipe_wb_entry.wr[0]) clr_mask[pipe_wb_entry.y1] = 1'b1;
            if (pipe_wb_entry.wr[1]) clr_mask[pipe_wb_entry.y2] = 1'b1;
        end
        pend_eff = pending_q & ~clr_mask;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_src_hit
        assign src_hit[gi] = src_use[gi]
                          && (src_sel[gi*REG_W +: REG_W] != zero_reg)
                          && pend_eff[src_sel[gi*REG_W +: REG_W]];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dst_hit
        assign dst_hit[gi] = alu_write[gi]
                          && (dst_sel[gi] != zero_reg)
                          && pend_eff[dst_sel[gi]];
    end

    assign hazard      = (|src_hit) || (|dst_hit);
    assign instr_ready = !drain && !hazard;
    assign issue       = instr_valid && instr_ready && active;
    assign pc_inc      = issue;
    assign stall       = instr_valid && !instr_ready && active;

    // Set is applied after clear so a same-cycle retire and re-claim leaves the bit set.
    always_comb begin
        set_mask = '0;
        for (int k = 0; k < 2; k++) begin
            if (issue && alu_write[k] && (dst_sel[k] != zero_reg)) begin
                set_mask[dst_sel[k]] = 1'b1;
            end
        end
        pending_d = pend_eff | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        push_entry    = '0;
        push_entry.wr = alu_write;
        push_entry.y1 = alu_Y1_select;
        push_entry.y2 = alu_Y2_select;
    end

    alu_wb_pipe #(
        .LAT (ALU_LAT)
    ) u_wb_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue),
        .push_entry (push_entry),
        .wb_valid   (pipe_wb_valid),
        .wb_entry   (pipe_wb_entry),
        .busy       (pipe_busy)
    );

    assign wb_valid     = pipe_wb_valid;
    assign wb_Y1_select = pipe_wb_entry.y1;
    assign wb_Y2_select = pipe_wb_entry.y2;
    assign wb_write     = pipe_wb_entry.wr;
    assign pending      = pending_q;
    assign drained      = drain && !pipe_busy && (pending_q == '0) && active;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: per-cycle vector table for issue/hazard/writeback,
// plus hand sequences for drain and mid-run reset.
module tb_alu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] src_sel;
    logic [3:0]  src_use;
    logic [3:0]  alu_Y1_select;
    logic [3:0]  alu_Y2_select;
    logic [1:0]  alu_write;
    logic [3:0]  zero_reg;
    logic        drain;
    logic        issue;
    logic        pc_inc;
    logic        stall;
    logic        drained;
    logic        wb_valid;
    logic [3:0]  wb_Y1_select;
    logic [3:0]  wb_Y2_select;
    logic [1:0]  wb_write;
    logic [15:0] pending;

    int    n_vec = 0;
    int    n_bad = 0;
    string tag;

    always #5 clk = ~clk;

    alu_issue_scheduler #(
        .ALU_LAT (3),
        .NREG    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .src_sel       (src_sel),
        .src_use       (src_use),
        .alu_Y1_select (alu_Y1_select),
        .alu_Y2_select (alu_Y2_select),
        .alu_write     (alu_write),
        .zero_reg      (zero_reg),
        .drain         (drain),
        .issue         (issue),
        .pc_inc        (pc_inc),
        .stall         (stall),
        .drained       (drained),
        .wb_valid      (wb_valid),
        .wb_Y1_select  (wb_Y1_select),
        .wb_Y2_select  (wb_Y2_select),
        .wb_write      (wb_write),
        .pending       (pending)
    );

    typedef struct {
        logic        iv;
        logic [15:0] src;
        logic [3:0]  uses;
        logic [3:0]  y1;
        logic [3:0]  y2;
        logic [1:0]  wr;
        logic [3:0]  zr;
        logic        e_issue;
        logic        e_stall;
        logic [15:0] e_pend;
        logic        e_wbv;
        logic [3:0]  e_wby1;
        logic [1:0]  e_wbwr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [15:0] src, input logic [3:0] uses,
                       input logic [3:0] y1, input logic [3:0] y2, input logic [1:0] wr,
                       input logic [3:0] zr, input logic e_issue, input logic e_stall,
                       input logic [15:0] e_pend, input logic e_wbv, input logic [3:0] e_wby1,
                       input logic [1:0] e_wbwr);
        vec_t v;
        v.iv = iv; v.src = src; v.uses = uses; v.y1 = y1; v.y2 = y2; v.wr = wr; v.zr = zr;
        v.e_issue = e_issue; v.e_stall = e_stall; v.e_pend = e_pend;
        v.e_wbv = e_wbv; v.e_wby1 = e_wby1; v.e_wbwr = e_wbwr;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [15:0] e_pend, input logic e_wbv, input logic [3:0] e_wby1,
                        input logic [1:0] e_wbwr);
        add(1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'hF, 1'b0, 1'b0, e_pend, e_wbv, e_wby1, e_wbwr);
    endtask

    task automatic drive(input logic iv, input logic [15:0] src, input logic [3:0] uses,
                         input logic [3:0] y1, input logic [3:0] y2, input logic [1:0] wr,
                         input logic [3:0] zr, input logic dr);
        instr_valid = iv; src_sel = src; src_use = uses; alu_Y1_select = y1;
        alu_Y2_select = y2; alu_write = wr; zero_reg = zr; drain = dr;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s %s: got %0h want %0h", tag, nm, act, req);
        end
    endtask

    localparam logic [15:0] S = 16'hBA98;

    initial begin
        // Independent stream, Y1=1..6, sources 8..11
        add(1, S, 4'hF, 4'd1, 0, 2'b01, 4'hF, 1, 0, 16'h0000, 0, 0, 0);
        add(1, S, 4'hF, 4'd2, 0, 2'b01, 4'hF, 1, 0, 16'h0002, 0, 0, 0);
        add(1, S, 4'hF, 4'd3, 0, 2'b01, 4'hF, 1, 0, 16'h0006, 0, 0, 0);
        add(1, S, 4'hF, 4'd4, 0, 2'b01, 4'hF, 1, 0, 16'h000E, 1, 4'd1, 2'b01);
        add(1, S, 4'hF, 4'd5, 0, 2'b01, 4'hF, 1, 0, 16'h001C, 1, 4'd2, 2'b01);
        add(1, S, 4'hF, 4'd6, 0, 2'b01, 4'hF, 1, 0, 16'h0038, 1, 4'd3, 2'b01);
        idle(16'h0070, 1, 4'd4, 2'b01);
        idle(16'h0060, 1, 4'd5, 2'b01);
        idle(16'h0040, 1, 4'd6, 2'b01);
        // RAW on r5, second op rewrites r5 (set wins over same-cycle clear)
        add(1, 16'h0001, 4'h1, 4'd5, 0, 2'b01, 4'hF, 1, 0, 16'h0000, 0, 0, 0);
        add(1, 16'h0005, 4'h1, 4'd5, 0, 2'b01, 4'hF, 0, 1, 16'h0020, 0, 0, 0);
        add(1, 16'h0005, 4'h1, 4'd5, 0, 2'b01, 4'hF, 0, 1, 16'h0020, 0, 0, 0);
        add(1, 16'h0005, 4'h1, 4'd5, 0, 2'b01, 4'hF, 1, 0, 16'h0020, 1, 4'd5, 2'b01);
        idle(16'h0020, 0, 0, 0);
        idle(16'h0020, 0, 0, 0);
        idle(16'h0020, 1, 4'd5, 2'b01);
        idle(16'h0000, 0, 0, 0);
        // Zero register never hazards nor sets pending
        add(1, 16'h0003, 4'h1, 4'd0, 0, 2'b01, 4'h0, 1, 0, 16'h0000, 0, 0, 0);
        add(1, 16'h0000, 4'h1, 4'd0, 0, 2'b01, 4'h0, 1, 0, 16'h0000, 0, 0, 0);
        idle(16'h0000, 0, 0, 0);
        idle(16'h0000, 1, 4'd0, 2'b01);
        idle(16'h0000, 1, 4'd0, 2'b01);
        // Dual write Y1=Y2=7, then WAW via Y2 only
        add(1, 16'h0000, 4'h0, 4'd7, 4'd7, 2'b11, 4'hF, 1, 0, 16'h0000, 0, 0, 0);
        add(1, 16'h0000, 4'h0, 4'd2, 4'd7, 2'b10, 4'hF, 0, 1, 16'h0080, 0, 0, 0);
        add(1, 16'h0000, 4'h0, 4'd2, 4'd7, 2'b10, 4'hF, 0, 1, 16'h0080, 0, 0, 0);
        add(1, 16'h0000, 4'h0, 4'd2, 4'd7, 2'b10, 4'hF, 1, 0, 16'h0080, 1, 4'd7, 2'b11);
        idle(16'h0080, 0, 0, 0);
        idle(16'h0080, 0, 0, 0);
        idle(16'h0080, 1, 4'd2, 2'b10);
        // alu_write=0 still occupies a slot
        add(1, 16'h0000, 4'h0, 4'd3, 0, 2'b00, 4'hF, 1, 0, 16'h0000, 0, 0, 0);
        idle(16'h0000, 0, 0, 0);
        idle(16'h0000, 0, 0, 0);
        idle(16'h0000, 1, 4'd3, 2'b00);

        rst = 1'b1;
        drive(0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'hF, 0);
        #2;
        tag = "reset";
        chk("pending", pending, 16'h0000);
        chk("wb_valid", wb_valid, 0);
        chk("instr_ready", instr_ready, 1);
        chk("issue", issue, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].iv, vq[i].src, vq[i].uses, vq[i].y1, vq[i].y2, vq[i].wr, vq[i].zr, 0);
            #1;
            tag = $sformatf("row%0d", i);
            chk("issue", issue, vq[i].e_issue);
            chk("pc_inc", pc_inc, vq[i].e_issue);
            chk("stall", stall, vq[i].e_stall);
            chk("instr_ready", instr_ready, !vq[i].e_stall);
            chk("pending", pending, vq[i].e_pend);
            chk("wb_valid", wb_valid, vq[i].e_wbv);
            if (vq[i].e_wbv) begin
                chk("wb_Y1_select", wb_Y1_select, vq[i].e_wby1);
                chk("wb_write", wb_write, vq[i].e_wbwr);
            end
            $display("row %0d: iv=%0b issue=%0b stall=%0b pending=%h wb_valid=%0b wb_y1=%0d",
                     i, instr_valid, issue, stall, pending, wb_valid, wb_Y1_select);
        end

        // Drain with two ops in flight
        tag = "drain";
        @(negedge clk); drive(1, S, 4'hF, 4'd1, 0, 2'b01, 4'hF, 0); #1;
        chk("issue0", issue, 1);
        @(negedge clk); drive(1, S, 4'hF, 4'd2, 0, 2'b01, 4'hF, 0); #1;
        chk("issue1", issue, 1);
        @(negedge clk); drive(1, S, 4'hF, 4'd3, 0, 2'b01, 4'hF, 1); #1;
        chk("ready_d2", instr_ready, 0);
        chk("issue_d2", issue, 0);
        chk("stall_d2", stall, 1);
        chk("drained_d2", drained, 0);
        @(negedge clk); #1;
        chk("wb_valid_d3", wb_valid, 1);
        chk("issue_d3", issue, 0);
        chk("drained_d3", drained, 0);
        @(negedge clk); #1;
        chk("wb_valid_d4", wb_valid, 1);
        chk("wb_y1_d4", wb_Y1_select, 4'd2);
        chk("pending_d4", pending, 16'h0004);
        chk("drained_d4", drained, 0);
        @(negedge clk); #1;
        chk("drained_d5", drained, 1);
        chk("pending_d5", pending, 16'h0000);
        chk("wb_valid_d5", wb_valid, 0);
        @(negedge clk); #1;
        chk("drained_d6", drained, 1);
        @(negedge clk); drive(0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'hF, 0); #1;
        chk("drained_d7", drained, 0);
        chk("ready_d7", instr_ready, 1);
        $display("drain sequence done: drained=%0b pending=%h", drained, pending);

        // Reset mid-run with r1,r2 in flight
        tag = "midreset";
        @(negedge clk); drive(1, S, 4'hF, 4'd1, 0, 2'b01, 4'hF, 0);
        @(negedge clk); drive(1, S, 4'hF, 4'd2, 0, 2'b01, 4'hF, 0);
        @(negedge clk); drive(0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'hF, 0); #1;
        chk("pending_pre", pending, 16'h0006);
        #2;
        rst = 1'b1;
        drive(1, 16'h0, 4'h0, 4'd4, 4'h0, 2'b01, 4'hF, 0);
        #1;
        chk("pending_rst", pending, 16'h0000);
        chk("wb_valid_rst", wb_valid, 0);
        chk("ready_rst", instr_ready, 1);
        chk("issue_rst", issue, 0);
        @(negedge clk);
        drive(0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'hF, 0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("wb_valid_post", wb_valid, 0);
            chk("pending_post", pending, 16'h0000);
        end
        $display("reset sequence done: pending=%h wb_valid=%0b", pending, wb_valid);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
